// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART constants (bit timing, data width, receiver
//                state encoding) and a parity helper. The transmitter and
//                the clock generator take CLKS_PER_BIT from here as well.
//  Options     : UART_RX_PARITY_EN selects 8E1 framing in the receiver
//                (the PARITY state is always defined here).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 50 MHz / 115200 baud, truncated
    localparam int CLKS_PER_BIT = 434;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int DATA_BITS    = 8;
    localparam int CNT_W        = 9;

    typedef logic [2:0] state_t;

    // Receiver state encoding
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Terminal counts of the bit-period counter
    localparam logic [CNT_W-1:0] c_CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);

    // Even-parity check: 1 when data plus parity bit hold an odd number of ones
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d,
                                        input logic p);
        return ^{d, p};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Host-side receive interface of the UART receiver.
//                master = receiver (drives data, valid and error pulses,
//                takes rx_ack); slave = host logic.
//  Signals     : rx_data[7:0], rx_valid, rx_ack, frame_err, overrun,
//                parity_err (only with UART_RX_PARITY_EN defined)
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 frame_err;
    logic                 overrun;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        input  rx_ack,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun
`ifdef UART_RX_PARITY_EN
        , output parity_err
`endif
    );

    modport slave (
        output rx_ack,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun
`ifdef UART_RX_PARITY_EN
        , input parity_err
`endif
    );

endinterface
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync2
//  Description : Two-flop synchroniser for a single asynchronous input.
//                Both flops reset to RESET_VAL so an idle-high line reads
//                as idle straight out of reset.
//  Ports       : clk, rst (async, active high), i_d (async input),
//                o_q (synchronised output)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver, 115200 baud on the 50 MHz clock. The line
//                is synchronised, a start edge is qualified at the start-bit
//                midpoint, and every further bit is sampled one bit period
//                later. Bytes go to the host with a valid/ack handshake.
//  Options     : UART_RX_PARITY_EN - 8E1 framing, adds parity_err pulse.
//  Ports       : clk_50m, rst (async, active high), rxd (async serial line),
//                rx_bus (uart_rx_if.master: rx_data, rx_valid, rx_ack,
//                frame_err, overrun[, parity_err])
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
(
    input  logic      clk_50m,
    input  logic      rst,
    input  logic      rxd,
    uart_rx_if.master rx_bus
);

    logic                 w_rxs;
    logic                 w_bit_end;
    logic                 r_rxs_d;
    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_idx;
    logic [DATA_BITS-1:0] r_sh;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_ovr;
`ifdef UART_RX_PARITY_EN
    logic                 r_par;
    logic                 r_perr;
`endif

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk_50m),
        .rst (rst),
        .i_d (rxd),
        .o_q (w_rxs)
    );

    assign w_bit_end = (r_cnt == c_CNT_BIT_LAST);

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_rxs_d <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sh    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_rxs_d <= w_rxs;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            // Ack clears valid; a byte completing in the same cycle
            // overrides this below and keeps valid high.
            if (r_valid && rx_bus.rx_ack) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    // Only a true high-to-low transition starts a frame, so a
                    // line stuck low (break, low at reset exit) never retriggers.
                    if (r_rxs_d && !w_rxs) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end

                START: begin
                    if (r_cnt == c_CNT_HALF_LAST) begin
                        r_cnt <= '0;
                        if (!w_rxs) begin
                            r_state <= DATA;
                            r_idx   <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        r_sh  <= {w_rxs, r_sh[DATA_BITS-1:1]};
                        if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_par   <= w_rxs;
                        r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (w_rxs) begin
                            r_data  <= r_sh;
                            r_valid <= 1'b1;
                            r_ovr   <= r_valid && !rx_bus.rx_ack;
`ifdef UART_RX_PARITY_EN
                            r_perr  <= parity_bad(r_sh, r_par);
`endif
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rx_bus.rx_data   = r_data;
    assign rx_bus.rx_valid  = r_valid;
    assign rx_bus.frame_err = r_ferr;
    assign rx_bus.overrun   = r_ovr;
`ifdef UART_RX_PARITY_EN
    assign rx_bus.parity_err = r_perr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. A sample-schedule model of
//                the receiver is compared against the DUT every cycle, and
//                directed frames are checked against hand-computed values.
//  Options     : UART_RX_PARITY_EN (must match the RTL build)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    import uart_pkg::*;

`ifdef UART_RX_PARITY_EN
    localparam int STOP_K  = 10;
    localparam int EXP_LAT = 4125 + 434;
`else
    localparam int STOP_K  = 9;
    localparam int EXP_LAT = 4125;
`endif

    logic clk_50m = 1'b0;
    logic rst     = 1'b1;
    logic rxd     = 1'b1;

    uart_rx_if bus ();

    uart_rx dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .rxd     (rxd),
        .rx_bus  (bus)
    );

    always #10 clk_50m = ~clk_50m;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // ---------------- model: sample schedule relative to the start edge ----
    logic       d1 = 1'b1, d2 = 1'b1, d3 = 1'b1;
    logic       line, prev;
    bit         m_busy = 0;
    int         m_off  = 0;
    int         k;
    logic [7:0] m_sh   = '0;
    logic       m_par  = 1'b0;
    logic [7:0] m_data = '0;
    logic       m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;
    logic       v_old;

    always @(posedge clk_50m) begin
        cyc++;
        if (rst) begin
            d1 = 1'b1; d2 = 1'b1; d3 = 1'b1;
            m_busy = 0; m_off = 0; m_sh = '0; m_par = 1'b0;
            m_data = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        end else begin
            // line as the receiver sees it: two cycles of synchroniser delay
            line   = d2;
            prev   = d3;
            v_old  = m_valid;
            m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
            if (m_valid && bus.rx_ack) m_valid = 1'b0;
            if (m_busy) begin
                m_off++;
                if (m_off == HALF_BIT) begin
                    if (line) m_busy = 0;
                end else if (m_off > HALF_BIT && ((m_off - HALF_BIT) % CLKS_PER_BIT) == 0) begin
                    k = (m_off - HALF_BIT) / CLKS_PER_BIT;
                    if (k <= 8) begin
                        m_sh[k-1] = line;
                    end else if (k < STOP_K) begin
                        m_par = line;
                    end else begin
                        m_busy = 0;
                        if (line) begin
                            m_ovr   = v_old && !bus.rx_ack;
                            m_valid = 1'b1;
                            m_data  = m_sh;
                            m_perr  = ^{m_sh, m_par};
                        end else begin
                            m_ferr = 1'b1;
                        end
                    end
                end
            end else if (prev && !line) begin
                m_busy = 1;
                m_off  = 0;
            end
            d3 = d2; d2 = d1; d1 = rxd;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- compare process + DUT event tracking ----------------
    logic       p_valid = 1'b0;
    int         last_rise = 0, n_rise = 0, n_ovr = 0, n_ferr = 0, n_perr = 0;
    logic [7:0] rise_data [$];

    always @(posedge clk_50m) begin
        #1;
        if (rst) begin
            p_valid = 1'b0;
        end else begin
            chk("cyc_rx_valid",  {31'd0, bus.rx_valid},  {31'd0, m_valid});
            chk("cyc_rx_data",   {24'd0, bus.rx_data},   {24'd0, m_data});
            chk("cyc_frame_err", {31'd0, bus.frame_err}, {31'd0, m_ferr});
            chk("cyc_overrun",   {31'd0, bus.overrun},   {31'd0, m_ovr});
`ifdef UART_RX_PARITY_EN
            chk("cyc_parity_err", {31'd0, bus.parity_err}, {31'd0, m_perr});
            if (bus.parity_err) n_perr++;
`endif
            if (bus.rx_valid && !p_valid) begin
                last_rise = cyc;
                n_rise++;
                rise_data.push_back(bus.rx_data);
            end
            p_valid = bus.rx_valid;
            if (bus.overrun)   n_ovr++;
            if (bus.frame_err) n_ferr++;
        end
    end

    // ---------------- stimulus helpers ----------------
    int fall_edge = 0;
    bit auto_ack  = 0;

    initial bus.rx_ack = 1'b0;

    initial begin : g_auto_ack
        int ack_wait;
        ack_wait = 0;
        forever begin
            @(negedge clk_50m);
            if (auto_ack && bus.rx_valid) begin
                ack_wait++;
                if (ack_wait == 10) begin
                    bus.rx_ack = 1'b1;
                    @(negedge clk_50m);
                    bus.rx_ack = 1'b0;
                    ack_wait = 0;
                end
            end else begin
                ack_wait = 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic bit_hold(input logic v);
        rxd = v;
        repeat (CLKS_PER_BIT) @(negedge clk_50m);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
        fall_edge = cyc + 1;
        bit_hold(1'b0);
        for (int i = 0; i < 8; i++) bit_hold(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_hold((^d) ^ par_flip);
`else
        if (par_flip) rxd = 1'b1;
`endif
        bit_hold(stop_v);
    endtask

    task automatic do_ack();
        bus.rx_ack = 1'b1;
        @(negedge clk_50m);
        bus.rx_ack = 1'b0;
        @(negedge clk_50m);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!bus.rx_valid && n < budget) begin
            @(negedge clk_50m);
            n++;
        end
        if (!bus.rx_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: rx_valid still 0 after %0d cycles, required 1", name, budget);
        end
    endtask

    // ---------------- directed tests ----------------
    int r0, o0, f0, p0;

    initial begin
        #15;
        chk("rst_rx_valid",  {31'd0, bus.rx_valid},  32'd0);
        chk("rst_rx_data",   {24'd0, bus.rx_data},   32'd0);
        chk("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        chk("rst_overrun",   {31'd0, bus.overrun},   32'd0);
        idle(3);
        rst = 1'b0;
        idle(20);

        // 0x55: latency and data
        f0 = n_ferr;
        send_frame(8'h55, 1'b1, 1'b0);
        wait_valid("t1_valid", 10);
        chk("t1_latency",  last_rise - fall_edge, EXP_LAT);
        chk("t1_data",     {24'd0, bus.rx_data}, 32'h55);
        chk("t1_no_ferr",  n_ferr - f0, 0);
        do_ack();
        idle(100);

        // 0xA3 + 0x0F back-to-back, auto-acked
        r0 = n_rise; o0 = n_ovr;
        auto_ack = 1;
        send_frame(8'hA3, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0);
        idle(50);
        auto_ack = 0;
        chk("t2_rises",   n_rise - r0, 2);
        chk("t2_first",   {24'd0, rise_data[r0]}, 32'hA3);
        chk("t2_second",  {24'd0, bus.rx_data}, 32'h0F);
        chk("t2_no_ovr",  n_ovr - o0, 0);
        idle(20);

        // 0x12 then 0x34 without ack: overrun
        o0 = n_ovr;
        send_frame(8'h12, 1'b1, 1'b0);
        idle(200);
        send_frame(8'h34, 1'b1, 1'b0);
        chk("t3_ovr_once", n_ovr - o0, 1);
        chk("t3_data",     {24'd0, bus.rx_data}, 32'h34);
        chk("t3_valid",    {31'd0, bus.rx_valid}, 32'd1);
        do_ack();
        idle(50);

        // 100-cycle low glitch
        r0 = n_rise; f0 = n_ferr;
        rxd = 1'b0;
        idle(100);
        rxd = 1'b1;
        idle(600);
        chk("t4_no_valid", n_rise - r0, 0);
        chk("t4_no_ferr",  n_ferr - f0, 0);

        // 0x7E with stop low, a break, then 0x81
        r0 = n_rise; f0 = n_ferr;
        send_frame(8'h7E, 1'b0, 1'b0);
        bit_hold(1'b0);
        rxd = 1'b1;
        idle(500);
        chk("t5_ferr_once", n_ferr - f0, 1);
        chk("t5_no_valid",  n_rise - r0, 0);
        chk("t5_valid_low", {31'd0, bus.rx_valid}, 32'd0);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_valid("t5_valid", 10);
        chk("t5_data", {24'd0, bus.rx_data}, 32'h81);

        // reset in bit 4 of 0xC6 while 0x81 is still pending
        bit_hold(1'b0);
        for (int i = 0; i < 4; i++) bit_hold(1'(8'hC6 >> i));
        rxd = 1'b0;
        idle(217);
        rst = 1'b1;
        rxd = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("t6_rst_data",  {24'd0, bus.rx_data},  32'd0);
        chk("t6_rst_ferr",  {31'd0, bus.frame_err}, 32'd0);
        chk("t6_rst_ovr",   {31'd0, bus.overrun},  32'd0);
        idle(5);
        rst = 1'b0;
        idle(50);
        f0 = n_ferr;
        send_frame(8'hC6, 1'b1, 1'b0);
        wait_valid("t6_valid", 10);
        chk("t6_data",    {24'd0, bus.rx_data}, 32'hC6);
        chk("t6_no_ferr", n_ferr - f0, 0);
        do_ack();
        idle(50);

`ifdef UART_RX_PARITY_EN
        p0 = n_perr;
        send_frame(8'hC6, 1'b1, 1'b1);
        wait_valid("t7_valid", 10);
        chk("t7_perr_once", n_perr - p0, 1);
        chk("t7_data",      {24'd0, bus.rx_data}, 32'hC6);
        do_ack();
        idle(20);
`else
        p0 = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
